// File: rtl/avg_seq_fsm.sv
// -----------------------------------------------------------------------------
// avg_seq_fsm
// Start/stop sample-averaging controller. It accumulates unsigned samples
// between start and stop, then computes floor(sum/count) with a sequential
// restoring divider (one quotient bit per clock, MSB first). The result is
// presented with a one-cycle out_valid pulse. A watchdog aborts a run that
// sees neither a sample nor a stop for TIMEOUT consecutive RUN cycles.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-low reset (0 = reset)
//   start       in   begin a run (honoured only in IDLE)
//   stop        in   end a run (honoured only in RUN)
//   sample_vld  in   din valid this cycle (honoured only in RUN)
//   din         in   sample value, unsigned, DATA_W bits
//   busy        out  1 whenever the controller is not idle
//   out_valid   out  one-cycle pulse, result fields valid
//   out_avg     out  floor(sum/count), 0 when count==0
//   out_count   out  samples accepted in the run
//   out_zero    out  run ended with no samples
//   timeout_err out  one-cycle pulse, run aborted by the watchdog
// -----------------------------------------------------------------------------
module avg_seq_fsm #(
   parameter int DATA_W  = 8,
   parameter int N_W     = 4,
   parameter int TIMEOUT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic              sample_vld,
   input  logic [DATA_W-1:0] din,
   output logic              busy,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_avg,
   output logic [N_W-1:0]    out_count,
   output logic              out_zero,
   output logic              timeout_err
);

   localparam int SUM_W = DATA_W + N_W;
   localparam int WD_W  = $clog2(TIMEOUT + 1);
   localparam int BIT_W = $clog2(SUM_W);

   // Count value just before the accept that makes it reach MAX_N.
   localparam logic [N_W-1:0]   N_LAST   = N_W'((2 ** N_W) - 2);
   // Watchdog value just before the idle cycle that makes it reach TIMEOUT.
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SUM_W - 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RUN  = 3'd1,
      DIV  = 3'd2,
      DONE = 3'd3,
      ERR  = 3'd4
   } state_t;

   // Kept as a raw 3-bit vector so the unused codes 5-7 are representable
   // and explicitly steered back to IDLE.
   logic [2:0]        state_q;
   state_t            state_d;

   // sum_q doubles as the dividend/quotient shift register during DIV:
   // dividend bits leave at the top while quotient bits enter at the bottom,
   // so after SUM_W shifts it holds the quotient.
   logic [SUM_W-1:0]  sum_q, sum_d;
   logic [N_W-1:0]    count_q, count_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic [N_W-1:0]    rem_q, rem_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [DATA_W-1:0] out_avg_q, out_avg_d;
   logic [N_W-1:0]    out_count_q, out_count_d;
   logic              out_zero_q, out_zero_d;

   // One restoring-division step. The remainder is always < count, so the
   // shifted partial remainder fits in N_W+1 bits and the difference fits
   // in N_W bits.
   logic [N_W:0]      rem_shift;
   logic [N_W-1:0]    rem_sub;
   logic              q_bit;

   always_comb begin
      rem_shift = {rem_q, sum_q[SUM_W-1]};
      q_bit     = (rem_shift >= {1'b0, count_q});
      rem_sub   = rem_shift[N_W-1:0] - count_q;
   end

   always_comb begin
      state_d     = IDLE;
      sum_d       = sum_q;
      count_d     = count_q;
      wd_d        = wd_q;
      rem_d       = rem_q;
      bit_d       = bit_q;
      out_avg_d   = out_avg_q;
      out_count_d = out_count_q;
      out_zero_d  = out_zero_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               sum_d   = '0;
               count_d = '0;
               wd_d    = '0;
            end else begin
               state_d = IDLE;
            end
         end

         RUN: begin
            state_d = RUN;
            if (sample_vld) begin
               sum_d   = sum_q + SUM_W'(din);
               count_d = count_q + 1'b1;
               wd_d    = '0;
               // Auto-stop once the count saturates so it can never wrap.
               if (stop || (count_q == N_LAST)) begin
                  state_d = DIV;
               end
            end else if (stop) begin
               state_d = DIV;
            end else begin
               wd_d = wd_q + 1'b1;
               if (wd_q == WD_LAST) begin
                  state_d = ERR;
               end
            end
            if (state_d == DIV) begin
               rem_d = '0;
               bit_d = '0;
            end
         end

         DIV: begin
            if (count_q == '0) begin
               // Guarded divide: an empty run finishes without dividing.
               state_d     = DONE;
               out_avg_d   = '0;
               out_count_d = '0;
               out_zero_d  = 1'b1;
            end else begin
               rem_d = q_bit ? rem_sub : rem_shift[N_W-1:0];
               sum_d = {sum_q[SUM_W-2:0], q_bit};
               bit_d = bit_q + 1'b1;
               if (bit_q == BIT_LAST) begin
                  state_d     = DONE;
                  // Quotient never exceeds 2**DATA_W-1, so the low bits
                  // are the whole result.
                  out_avg_d   = {sum_q[DATA_W-2:0], q_bit};
                  out_count_d = count_q;
                  out_zero_d  = 1'b0;
               end else begin
                  state_d = DIV;
               end
            end
         end

         DONE:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         sum_q       <= '0;
         count_q     <= '0;
         wd_q        <= '0;
         rem_q       <= '0;
         bit_q       <= '0;
         out_avg_q   <= '0;
         out_count_q <= '0;
         out_zero_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         sum_q       <= sum_d;
         count_q     <= count_d;
         wd_q        <= wd_d;
         rem_q       <= rem_d;
         bit_q       <= bit_d;
         out_avg_q   <= out_avg_d;
         out_count_q <= out_count_d;
         out_zero_q  <= out_zero_d;
      end
   end

   // Pulses decode directly from the state register; DONE and ERR are
   // distinct codes, so out_valid and timeout_err are mutually exclusive.
   always_comb begin
      busy        = (state_q == RUN) || (state_q == DIV) ||
                    (state_q == DONE) || (state_q == ERR);
      out_valid   = (state_q == DONE);
      timeout_err = (state_q == ERR);
      out_avg     = out_avg_q;
      out_count   = out_count_q;
      out_zero    = out_zero_q;
   end

endmodule

// File: tb/tb_avg_seq_fsm.sv
module tb_avg_seq_fsm;

   localparam int DATA_W  = 8;
   localparam int N_W     = 4;
   localparam int TIMEOUT = 4;
   localparam int SUM_W   = DATA_W + N_W;
   localparam int MAX_N   = (2 ** N_W) - 1;

   logic              clk;
   logic              rst;
   logic              start;
   logic              stop;
   logic              sample_vld;
   logic [DATA_W-1:0] din;
   logic              busy;
   logic              out_valid;
   logic [DATA_W-1:0] out_avg;
   logic [N_W-1:0]    out_count;
   logic              out_zero;
   logic              timeout_err;

   avg_seq_fsm #(
      .DATA_W (DATA_W),
      .N_W    (N_W),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stop       (stop),
      .sample_vld (sample_vld),
      .din        (din),
      .busy       (busy),
      .out_valid  (out_valid),
      .out_avg    (out_avg),
      .out_count  (out_count),
      .out_zero   (out_zero),
      .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Last result the bench expects to be held on the output fields.
   int last_avg  = 0;
   int last_cnt  = 0;
   int last_zero = 0;

   int smp [0:19];

   typedef struct {
      int               n;
      bit               stop_last;
      logic [7:0][7:0]  s;          // samples 0..7; later samples repeat s[7]
      int               exp_avg;
      int               exp_cnt;
      bit               exp_zero;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Reference: the first MAX_N offered samples are accepted; average is
   // the floor of their mean, zero when nothing was accepted.
   function automatic void model(input int n, output int a, output int c, output int z);
      int s;
      s = 0;
      c = (n > MAX_N) ? MAX_N : n;
      for (int i = 0; i < c; i++) s += smp[i];
      a = (c == 0) ? 0 : s / c;
      z = (c == 0) ? 1 : 0;
   endfunction

   task automatic do_run(input string nm, input int n, input bit stop_last, input int gap_max,
                         input int exp_avg, input int exp_cnt, input int exp_zero);
      int e0;
      int g;
      int exp_lat;
      exp_lat = (exp_cnt == 0) ? 1 : SUM_W;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({nm, ".busy_run"}, int'(busy), 1);
      e0 = -1;
      for (int i = 0; i < n; i++) begin
         g = (gap_max > 0 && i < MAX_N) ? int'($urandom_range(0, gap_max)) : 0;
         repeat (g) tick();
         sample_vld = 1'b1;
         din        = 8'(smp[i]);
         stop       = stop_last && (i == n - 1);
         tick();
         sample_vld = 1'b0;
         stop       = 1'b0;
         if (e0 < 0 && ((i == MAX_N - 1) || (stop_last && i == n - 1))) e0 = cyc;
      end
      if (e0 < 0) begin
         stop = 1'b1;
         tick();
         stop = 1'b0;
         e0 = cyc;
      end
      while (out_valid !== 1'b1 && timeout_err !== 1'b1 && (cyc - e0) < 40) tick();
      chk({nm, ".latency"}, cyc - e0, exp_lat);
      chk({nm, ".out_valid"}, int'(out_valid), 1);
      chk({nm, ".no_tmo"}, int'(timeout_err), 0);
      chk({nm, ".avg"}, int'(out_avg), exp_avg);
      chk({nm, ".count"}, int'(out_count), exp_cnt);
      chk({nm, ".zero"}, int'(out_zero), exp_zero);
      chk({nm, ".busy_done"}, int'(busy), 1);
      $display("run %s n=%0d stop_last=%0d avg=%0d count=%0d zero=%0d lat=%0d",
               nm, n, stop_last, out_avg, out_count, out_zero, cyc - e0);
      tick();
      chk({nm, ".pulse_end"}, int'(out_valid), 0);
      chk({nm, ".idle"}, int'(busy), 0);
      last_avg  = exp_avg;
      last_cnt  = exp_cnt;
      last_zero = exp_zero;
   endtask

   task automatic do_timeout(input string nm, input bit pre_sample);
      start = 1'b1;
      tick();
      start = 1'b0;
      if (pre_sample) begin
         sample_vld = 1'b1;
         din        = 8'($urandom_range(0, 255));
         tick();
         sample_vld = 1'b0;
      end
      repeat (TIMEOUT - 1) begin
         tick();
         chk({nm, ".early"}, int'(timeout_err), 0);
      end
      tick();
      chk({nm, ".tmo_pulse"}, int'(timeout_err), 1);
      chk({nm, ".no_valid"}, int'(out_valid), 0);
      chk({nm, ".busy_err"}, int'(busy), 1);
      chk({nm, ".avg_kept"}, int'(out_avg), last_avg);
      tick();
      chk({nm, ".tmo_end"}, int'(timeout_err), 0);
      chk({nm, ".idle"}, int'(busy), 0);
      chk({nm, ".cnt_kept"}, int'(out_count), last_cnt);
      chk({nm, ".zero_kept"}, int'(out_zero), last_zero);
      $display("timeout %s pre_sample=%0d avg=%0d count=%0d", nm, pre_sample, out_avg, out_count);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: got simulation still running expected finish");
      $fatal(1);
   end

   initial begin
      int ea, ec, ez, n;
      bit sl;
      bit seen;

      rst = 1'b0; start = 1'b0; stop = 1'b0; sample_vld = 1'b0; din = '0;

      vecs[0] = '{3,  1'b0, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd30, 8'd20, 8'd10}, 20, 3, 1'b0};
      vecs[1] = '{0,  1'b0, {8{8'd0}}, 0, 0, 1'b1};
      vecs[2] = '{16, 1'b0, {8{8'd255}}, 255, 15, 1'b0};
      vecs[3] = '{3,  1'b1, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd6, 8'd2, 8'd1}, 3, 3, 1'b0};
      vecs[4] = '{2,  1'b0, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd2, 8'd1}, 1, 2, 1'b0};
      vecs[5] = '{7,  1'b1, {8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd100}, 14, 7, 1'b0};
      vecs[6] = '{1,  1'b0, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255}, 255, 1, 1'b0};
      // 7 ones then 8 x 200: 1607/15 = 107, stop coincides with the 15th sample
      vecs[7] = '{15, 1'b1, {8'd200, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1}, 107, 15, 1'b0};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset.busy", int'(busy), 0);
      chk("reset.out_valid", int'(out_valid), 0);
      chk("reset.avg", int'(out_avg), 0);
      chk("reset.count", int'(out_count), 0);
      chk("reset.zero", int'(out_zero), 0);
      chk("reset.tmo", int'(timeout_err), 0);
      rst = 1'b1;
      tick();

      // start while idle-only: stop/sample alone must not leave IDLE
      stop = 1'b1; sample_vld = 1'b1; din = 8'd77;
      tick();
      stop = 1'b0; sample_vld = 1'b0;
      chk("idle.ignore", int'(busy), 0);

      // Table-driven runs
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < 20; i++) smp[i] = int'(vecs[k].s[(i < 8) ? i : 7]);
         do_run($sformatf("vec%0d", k), vecs[k].n, vecs[k].stop_last, 0,
                vecs[k].exp_avg, vecs[k].exp_cnt, int'(vecs[k].exp_zero));
      end

      // Watchdog abort keeps the previous result
      do_timeout("tmo0", 1'b0);

      // Asynchronous reset in the middle of a divide
      smp[0] = 50; smp[1] = 60;
      start = 1'b1; tick(); start = 1'b0;
      sample_vld = 1'b1; din = 8'd50; tick();
      din = 8'd60; tick();
      sample_vld = 1'b0; stop = 1'b1; tick(); stop = 1'b0;
      repeat (5) tick();
      chk("rstdiv.busy_before", int'(busy), 1);
      #3 rst = 1'b0;
      #1;
      chk("rstdiv.busy", int'(busy), 0);
      chk("rstdiv.avg", int'(out_avg), 0);
      chk("rstdiv.count", int'(out_count), 0);
      chk("rstdiv.zero", int'(out_zero), 0);
      chk("rstdiv.valid", int'(out_valid), 0);
      #2 rst = 1'b1;
      seen = 1'b0;
      repeat (15) begin
         tick();
         if (out_valid === 1'b1 || timeout_err === 1'b1 || busy === 1'b1) seen = 1'b1;
      end
      chk("rstdiv.quiet", int'(seen), 0);
      $display("reset mid-divide avg=%0d count=%0d busy=%0d", out_avg, out_count, busy);
      last_avg = 0; last_cnt = 0; last_zero = 0;

      // Give the output fields a nonzero value, then force illegal codes
      for (int i = 0; i < 20; i++) smp[i] = 9;
      do_run("pre_illegal", 2, 1'b0, 0, 9, 2, 0);
      force dut.state_q = 3'd6;
      #2 release dut.state_q;
      tick();
      chk("illegal6.recover", int'(dut.state_q), 0);
      chk("illegal6.busy", int'(busy), 0);
      chk("illegal6.avg_kept", int'(out_avg), last_avg);
      force dut.state_q = 3'd7;
      #2 release dut.state_q;
      tick();
      chk("illegal7.recover", int'(dut.state_q), 0);
      chk("illegal7.cnt_kept", int'(out_count), last_cnt);
      $display("illegal state recovery busy=%0d avg=%0d", busy, out_avg);

      // Randomized runs against the reference model
      for (int r = 0; r < 30; r++) begin
         if ($urandom_range(0, 5) == 0) begin
            do_timeout($sformatf("rtmo%0d", r), 1'($urandom_range(0, 1)));
         end else begin
            n  = int'($urandom_range(0, 17));
            sl = 1'($urandom_range(0, 1));
            for (int i = 0; i < 20; i++) smp[i] = int'($urandom_range(0, 255));
            model(n, ea, ec, ez);
            do_run($sformatf("rnd%0d", r), n, sl, 3, ea, ec, ez);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
